serial_cla_sub: RTL
===================

Name: serial_cla_sub

Overview:
- Multi-cycle subtractor, the counterpart of the team's 4-bit carry-lookahead adder.
- Computes a - b - bin over WIDTH bits, one 4-bit CLA nibble per clock, LSB nibble first.
- Uses ready/valid handshakes on input and result.
- Sits in the datapath where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NNIB, WIDTH/4, nibble count; derived localparam, not overridable.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operands a, b, bin are valid.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in, for chaining wider subtractions.
- done_valid  output  1  result is valid.
- done_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out (1 = unsigned a < b + bin).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, start_ready=1, done_valid=0, diff=0, bout=0, ovf=0, nibble index=0, carry register=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready at edge k:
  - latch a and ~b into shift registers;
  - carry register = ~bin;
  - index = 0;
  - go to RUN.
  - start_ready drops to 0 after edge k.
- RUN, each cycle:
  - slice computes nibble[idx] of a + ~b + carry with 4-bit CLA (generate/propagate; c1..c4 in parallel, no ripple);
  - sum nibble written to diff[4*idx+3:4*idx];
  - carry register = c4;
  - idx increments.
  - After the nibble with idx = NNIB-1 (edge k+NNIB), go to DONE.
- Latency: done_valid is high starting edge k+NNIB (4 cycles for WIDTH=16).
- On entering DONE:
  - bout = ~final carry;
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed on the latched operands.
- DONE:
  - done_valid=1; diff, bout, ovf held stable.
  - On done_valid&&done_ready, return to IDLE; start_ready=1 from the next cycle.
  - No same-cycle result accept plus new start; minimum issue interval is NNIB+2 cycles.
- Inputs ignored: start_valid while not in IDLE; done_ready while not in DONE.
- diff during RUN: partially updated; consumers use it only when done_valid=1.
- Operand stability: a, b, bin are sampled only at the accept edge. Later changes have no effect.
- Reset mid-operation (RUN or DONE): the operation is abandoned and all outputs return to reset values on the next edge. No result is produced.
- Width rules:
  - internal carry is 1 bit; idx is clog2(NNIB) bits, minimum 1;
  - operand shift registers shift right by 4 per RUN cycle.

Decomposition:
- Shared package serial_cla_pkg:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_W = 4 constant;
  - function for signed overflow.
- Sub-module cla4_slice, purely combinational:
  - inputs: 4-bit x, 4-bit y, cin;
  - outputs: 4-bit s, cout;
  - explicit generate/propagate lookahead equations.
- Top module: FSM, operand shift registers, carry register, result register.

Test Plan:
- Basic subtract, WIDTH=16: a=0x1234, b=0x0234, bin=0 → done_valid 4 cycles after accept; diff=0x1000, bout=0, ovf=0.
- Unsigned underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0.
- Signed overflow: a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- Borrow-in chaining: a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1. Then a=0x0010, b=0x0001, bin=1 → diff=0x000E, bout=0.
- Backpressure: hold done_ready=0 for 5 cycles with start_valid=1 and changing a/b → diff, bout, ovf stable; start_ready=0; no new accept. Raise done_ready → IDLE next cycle; then the new operand is accepted.
- Reset mid-run: assert rst during the 2nd RUN cycle → next edge: done_valid=0, start_ready=1, diff=0. A following op 0x00FF-0x000F gives diff=0x00F0 with normal 4-cycle latency.

Source files
------------

// File: rtl/serial_cla_sub_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead subtractor.
package serial_cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow of a - b: operand signs differ and the result sign left a's.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic diff_msb);
        return (a_msb != b_msb) && (diff_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_cla_sub_if.sv
// Operand/result bundle of the serial subtractor.
// A transfer happens on a rising clock edge where valid && ready are both high; the
// sender holds its payload steady while valid is high and ready is low.
interface serial_cla_sub_if #(parameter int WIDTH = 16);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start_valid, a, b, bin, done_ready,
        input  start_ready, done_valid, diff, bout, ovf
    );

    modport slave (
        input  start_valid, a, b, bin, done_ready,
        output start_ready, done_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_cla_sub_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice; all carries come straight from g/p/cin.
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    assign g = x & y;
    assign p = x ^ y;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ {c[3:1], cin};
    assign cout = c[4];
endmodule

// File: rtl/serial_cla_sub.sv
// Multi-cycle a - b - bin: one CLA nibble of a + ~b + ~bin per clock, LSB nibble first.
module serial_cla_sub
    import serial_cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    serial_cla_sub_if.slave bus,
    output state_t          dbg_state
);
    localparam int NNIB  = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_nb;
    logic               a_msb;
    logic               b_msb;
    logic               start_ready_r;
    logic               done_valid_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;
    logic               ovf_r;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    cla4_slice u_slice (
        .x    (sh_a[NIBBLE_W-1:0]),
        .y    (sh_nb[NIBBLE_W-1:0]),
        .cin  (carry),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b1;
            sh_a          <= '0;
            sh_nb         <= '0;
            a_msb         <= 1'b0;
            b_msb         <= 1'b0;
            start_ready_r <= 1'b1;
            done_valid_r  <= 1'b0;
            diff_r        <= '0;
            bout_r        <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid && start_ready_r) begin
                        sh_a          <= bus.a;
                        sh_nb         <= ~bus.b;
                        carry         <= ~bus.bin;
                        a_msb         <= bus.a[WIDTH-1];
                        b_msb         <= bus.b[WIDTH-1];
                        idx           <= '0;
                        start_ready_r <= 1'b0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    diff_r[int'(idx)*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry <= nib_cout;
                    sh_a  <= sh_a >> NIBBLE_W;
                    sh_nb <= sh_nb >> NIBBLE_W;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        // The top nibble's sum bit is the result sign used for overflow.
                        bout_r       <= ~nib_cout;
                        ovf_r        <= signed_ovf(a_msb, b_msb, nib_sum[NIBBLE_W-1]);
                        idx          <= '0;
                        done_valid_r <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        done_valid_r  <= 1'b0;
                        start_ready_r <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    start_ready_r <= 1'b1;
                    done_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.diff        = diff_r;
    assign bus.bout        = bout_r;
    assign bus.ovf         = ovf_r;
    assign dbg_state       = state;
endmodule
